// File: rtl/regfile_wb_if.sv
// Write-back / register-read bus between control/datapath and the register file.
interface regfile_wb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              regwrite;
    logic              jal;
    logic              memtoreg;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  commit_cnt;
    logic [CNT_W-1:0]  load_cnt;

    // Driver side: pipeline control and decode.
    modport master (
        output regwrite, jal, memtoreg, wr_addr, wr_data,
        output rd_addr1, rd_addr2, dbg_addr,
        input  rd_data1, rd_data2, dbg_data, commit_cnt, load_cnt
    );

    // Register file side.
    modport slave (
        input  regwrite, jal, memtoreg, wr_addr, wr_data,
        input  rd_addr1, rd_addr2, dbg_addr,
        output rd_data1, rd_data2, dbg_data, commit_cnt, load_cnt
    );
endinterface

// File: rtl/regfile_wb.sv
// Write-back register file: 2**ADDR_W x DATA_W, r0 hardwired to zero, JAL link
// override, write-through read bypass, registered debug port, commit counters.
module regfile_wb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned CNT_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wb_if.slave  bus
);
    localparam int unsigned N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic [DATA_W-1:0] r_dbg_data;
    logic [CNT_W-1:0]  r_commit_cnt;
    logic [CNT_W-1:0]  r_load_cnt;

    logic [ADDR_W-1:0] w_eff_addr;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;

    // Destination decode and commit qualification; r0 writes are dropped.
    always_comb begin
        w_eff_addr = bus.jal ? ADDR_W'(LINK_REG) : bus.wr_addr;
        w_commit   = bus.regwrite && !reset && (w_eff_addr != '0);
    end

    // Read ports: r0 reads zero, same-cycle commit is forwarded.
    always_comb begin
        w_rd_data1 = '0;
        w_rd_data2 = '0;
        if (bus.rd_addr1 != '0) begin
            if (w_commit && (bus.rd_addr1 == w_eff_addr)) w_rd_data1 = bus.wr_data;
            else                                           w_rd_data1 = r_regs[bus.rd_addr1];
        end
        if (bus.rd_addr2 != '0) begin
            if (w_commit && (bus.rd_addr2 == w_eff_addr)) w_rd_data2 = bus.wr_data;
            else                                           w_rd_data2 = r_regs[bus.rd_addr2];
        end
    end

    // Storage, debug snapshot (pre-write, no bypass) and commit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_dbg_data   <= '0;
            r_commit_cnt <= '0;
            r_load_cnt   <= '0;
        end else begin
            r_dbg_data <= (bus.dbg_addr == '0) ? '0 : r_regs[bus.dbg_addr];
            if (w_commit) begin
                r_regs[w_eff_addr] <= bus.wr_data;
                r_commit_cnt       <= r_commit_cnt + CNT_W'(1);
                if (bus.memtoreg) begin
                    r_load_cnt <= r_load_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.rd_data1   = w_rd_data1;
    assign bus.rd_data2   = w_rd_data2;
    assign bus.dbg_data   = r_dbg_data;
    assign bus.commit_cnt = r_commit_cnt;
    assign bus.load_cnt   = r_load_cnt;

    // jal together with memtoreg is an illegal control combination.
    a_no_jal_load: assert property (@(posedge clk) disable iff (reset)
        !(bus.regwrite && bus.jal && bus.memtoreg))
        else $error("regfile_wb: jal and memtoreg asserted together");

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: a reference model predicts read ports,
// debug data and counters; registered expectations go through a queue.
module tb_regfile_wb;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 32;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))     bus4 ();

    regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(31), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow-counter copy fed the same stimulus, used to exercise wrap.
    regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(31), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus4.regwrite = bus.regwrite;
    assign bus4.jal      = bus.jal;
    assign bus4.memtoreg = bus.memtoreg;
    assign bus4.wr_addr  = bus.wr_addr;
    assign bus4.wr_data  = bus.wr_data;
    assign bus4.rd_addr1 = bus.rd_addr1;
    assign bus4.rd_addr2 = bus.rd_addr2;
    assign bus4.dbg_addr = bus.dbg_addr;

    typedef struct {
        logic [31:0] dbg;
        logic [31:0] cc;
        logic [31:0] lc;
        logic [3:0]  cc4;
    } exp_t;

    exp_t        q_exp[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cc;
    logic [31:0] m_lc;
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus: check comb reads, queue registered expectations,
    // then compare the DUT's registered outputs after the edge.
    task automatic step(input logic rst, input logic rw, input logic j, input logic mt,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
        logic [4:0]  ea;
        logic        cm;
        logic [31:0] x1;
        logic [31:0] x2;
        exp_t        e;
        @(negedge clk);
        reset        = rst;
        bus.regwrite = rw;
        bus.jal      = j;
        bus.memtoreg = mt;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr1 = a1;
        bus.rd_addr2 = a2;
        bus.dbg_addr = da;
        ea = j ? 5'd31 : wa;
        cm = rw && !rst && (ea != 5'd0);
        x1 = (a1 == 5'd0) ? 32'd0 : ((cm && a1 == ea) ? wd : m_regs[a1]);
        x2 = (a2 == 5'd0) ? 32'd0 : ((cm && a2 == ea) ? wd : m_regs[a2]);
        #1;
        check("rd_data1", 64'(bus.rd_data1), 64'(x1));
        check("rd_data2", 64'(bus.rd_data2), 64'(x2));
        e.dbg = (da == 5'd0) ? 32'd0 : m_regs[da];
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cc  = 32'd0;
            m_lc  = 32'd0;
            e.dbg = 32'd0;
        end else if (cm) begin
            m_regs[ea] = wd;
            m_cc       = m_cc + 32'd1;
            if (mt) m_lc = m_lc + 32'd1;
        end
        e.cc  = m_cc;
        e.lc  = m_lc;
        e.cc4 = m_cc[3:0];
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            e = q_exp.pop_front();
            check("dbg_data",    64'(bus.dbg_data),    64'(e.dbg));
            check("commit_cnt",  64'(bus.commit_cnt),  64'(e.cc));
            check("load_cnt",    64'(bus.load_cnt),    64'(e.lc));
            check("commit_cnt4", 64'(bus4.commit_cnt), 64'(e.cc4));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_cc    = 32'd0;
        m_lc    = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        reset        = 1'b1;
        bus.regwrite = 1'b0;
        bus.jal      = 1'b0;
        bus.memtoreg = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        bus.dbg_addr = '0;

        // Reset, then check the reset state through reads and debug.
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd5);

        // Basic write then read.
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);

        // Same-cycle bypass on both ports; debug sees pre-write value.
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5, 5'd7);

        // JAL forces r31; r9 untouched.
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h00400008, 5'd31, 5'd9, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd9, 5'd31);

        // Write to r0 dropped and not counted.
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // regwrite=0 ignores jal/memtoreg.
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'hA5A5A5A5, 5'd31, 5'd3, 5'd31);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd31, 5'd3);

        // Loads into r1..r3 after a fresh reset, then reset with concurrent write.
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i <= 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 5'(i), 32'h1000 + 32'(i), 5'(i), 5'd0, 5'(i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'hCAFEF00D, 5'd4, 5'd1, 5'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd2, 5'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0BADC0DE, 5'd4, 5'd1, 5'd4);

        // Random traffic; reads sometimes aimed at the write target.
        for (int n = 0; n < 200; n++) begin
            logic        rw;
            logic        j;
            logic        mt;
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            rw = 1'($urandom_range(0, 3) != 0);
            j  = 1'($urandom_range(0, 5) == 0);
            mt = j ? 1'b0 : 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? (j ? 5'd31 : wa) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 49) == 0), rw, j, mt, wa, 32'($urandom),
                 a1, a2, 5'($urandom_range(0, 31)));
        end

        // Counter wrap on the 4-bit instance: 16 commits bring it back to 0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 1'b0, 1'(i & 1), 5'((i % 31) + 1), 32'(i * 7 + 1),
                 5'((i % 31) + 1), 5'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
